idct_x5: RTL and testbench

IDCT_X5 -- requirements
Module: idct_x5

---
 rtl/idct_pkg.sv | 30 +++
 rtl/idct_x5_rom.sv | 56 +++++
 rtl/idct_x5.sv | 121 ++++++++++++
 tb/tb_idct_x5.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Constants and types shared by the idct_xN single-sample IDCT blocks.
package idct_pkg;

    localparam int unsigned COEF_W = 19;
    localparam int unsigned ROM_W  = 16;
    localparam int unsigned FRAC   = 14;
    localparam int unsigned ACC_W  = 38;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Clamp a full-width signed value to the signed OUT_W output range.
    function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] y);
        logic [ACC_W-OUT_W:0] hi;
        hi = y[ACC_W-1:OUT_W-1];
        if ((&hi) || (~|hi)) begin
            return y[OUT_W-1:0];
        end else if (y[ACC_W-1]) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/idct_x5_rom.sv
// Distributed-arithmetic partial-sum tables for sample x[5], Q1.14.
// ROM_A covers X[0..3], ROM_B covers X[4..7]; address bit i selects coefficient i.
module idct_x5_rom
    import idct_pkg::*;
(
    input  logic [3:0]              addr_a,
    input  logic [3:0]              addr_b,
    output logic signed [ROM_W-1:0] data_a,
    output logic signed [ROM_W-1:0] data_b
);

    always_comb begin
        data_a = '0;
        case (addr_a)
            4'd0:  data_a = 16'sd0;
            4'd1:  data_a = 16'sd5793;
            4'd2:  data_a = -16'sd4551;
            4'd3:  data_a = 16'sd1241;
            4'd4:  data_a = -16'sd3135;
            4'd5:  data_a = 16'sd2658;
            4'd6:  data_a = -16'sd7686;
            4'd7:  data_a = -16'sd1894;
            4'd8:  data_a = 16'sd8035;
            4'd9:  data_a = 16'sd13827;
            4'd10: data_a = 16'sd3483;
            4'd11: data_a = 16'sd9276;
            4'd12: data_a = 16'sd4900;
            4'd13: data_a = 16'sd10692;
            4'd14: data_a = 16'sd348;
            4'd15: data_a = 16'sd6141;
        endcase
    end

    always_comb begin
        data_b = '0;
        case (addr_b)
            4'd0:  data_b = 16'sd0;
            4'd1:  data_b = -16'sd5793;
            4'd2:  data_b = -16'sd1598;
            4'd3:  data_b = -16'sd7391;
            4'd4:  data_b = 16'sd7568;
            4'd5:  data_b = 16'sd1776;
            4'd6:  data_b = 16'sd5970;
            4'd7:  data_b = 16'sd178;
            4'd8:  data_b = -16'sd6811;
            4'd9:  data_b = -16'sd12604;
            4'd10: data_b = -16'sd8410;
            4'd11: data_b = -16'sd14202;
            4'd12: data_b = 16'sd757;
            4'd13: data_b = -16'sd5036;
            4'd14: data_b = -16'sd841;
            4'd15: data_b = -16'sd6634;
        endcase
    end

endmodule

// File: rtl/idct_x5.sv
// Bit-serial distributed-arithmetic IDCT producing the single sample x[5]
// from eight signed coefficients; one result every 21 enabled cycles.
module idct_x5
    import idct_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic signed [COEF_W-1:0] coef0,
    input  logic signed [COEF_W-1:0] coef1,
    input  logic signed [COEF_W-1:0] coef2,
    input  logic signed [COEF_W-1:0] coef3,
    input  logic signed [COEF_W-1:0] coef4,
    input  logic signed [COEF_W-1:0] coef5,
    input  logic signed [COEF_W-1:0] coef6,
    input  logic signed [COEF_W-1:0] coef7,
    output logic                     busy,
    output logic                     done,
    output logic signed [OUT_W-1:0]  sample_out
);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (FRAC - 1));

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [7:0][COEF_W-1:0]       sr_q, sr_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [OUT_W-1:0]             sample_q, sample_d;

    logic [3:0]                   addr_a, addr_b;
    logic signed [ROM_W-1:0]      rom_a, rom_b;
    logic signed [ACC_W-1:0]      term;
    logic signed [ACC_W-1:0]      rnd;
    logic signed [ACC_W-1:0]      y;

    // Current bit slice of each coefficient forms the ROM addresses.
    assign addr_a = {sr_q[3][0], sr_q[2][0], sr_q[1][0], sr_q[0][0]};
    assign addr_b = {sr_q[7][0], sr_q[6][0], sr_q[5][0], sr_q[4][0]};

    idct_x5_rom u_rom (
        .addr_a (addr_a),
        .addr_b (addr_b),
        .data_a (rom_a),
        .data_b (rom_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sr_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= '0;
        end else if (en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sr_q     <= sr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sr_d     = sr_q;
        sample_d = sample_q;
        done_d   = 1'b0;
        term     = (ACC_W'(rom_a) + ACC_W'(rom_b)) <<< cnt_q;
        rnd      = acc_q + RND_HALF;
        y        = rnd >>> FRAC;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sr_d    = {coef7, coef6, coef5, coef4, coef3, coef2, coef1, coef0};
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                for (int i = 0; i < 8; i++) begin
                    sr_d[i] = {1'b0, sr_q[i][COEF_W-1:1]};
                end
                // The top bit carries negative weight in two's complement.
                if (cnt_q == CNT_W'(COEF_W - 1)) begin
                    acc_d   = acc_q - term;
                    state_d = FINISH;
                end else begin
                    acc_d = acc_q + term;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH: begin
                sample_d = sat_out(y);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Busy stays up through the done cycle.
        busy_d = (state_d != IDLE) || done_d;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_out = sample_q;

endmodule

// File: tb/tb_idct_x5.sv
// Directed bench for idct_x5: reset, DC/AC/mixed vectors, saturation,
// ignored restarts, clock-enable stalls and mid-run reset.
module tb_idct_x5;

    logic              clk;
    logic              rst;
    logic              en;
    logic              start;
    logic signed [18:0] coef [8];
    logic              busy;
    logic              done;
    logic signed [7:0] sample_out;

    int checks   = 0;
    int failures = 0;

    idct_x5 dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .coef0      (coef[0]),
        .coef1      (coef[1]),
        .coef2      (coef[2]),
        .coef3      (coef[3]),
        .coef4      (coef[4]),
        .coef5      (coef[5]),
        .coef6      (coef[6]),
        .coef7      (coef[7]),
        .busy       (busy),
        .done       (done),
        .sample_out (sample_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_coefs();
        for (int i = 0; i < 8; i++) coef[i] = '0;
    endtask

    // Issue start, then run until done; optional enable gap and ignored restarts.
    task automatic run_op(input string tag, input int exp_val, input int exp_lat,
                          input int dis_at, input int dis_len, input bit spoil);
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_start"}, int'(busy), 1);
        n = 0;
        while (!done && n < 60) begin
            en = !(n >= dis_at && n < dis_at + dis_len);
            if (spoil && (n == 5 || n == 10)) begin
                start   = 1'b1;
                coef[0] = 19'sd362;
            end
            step();
            start = 1'b0;
            n++;
        end
        en = 1'b1;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_value"}, int'(sample_out), exp_val);
        check({tag, "_busy_done"}, int'(busy), 1);
    endtask

    task automatic expect_idle(input string tag);
        step();
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_done"}, int'(done), 0);
    endtask

    task automatic count_quiet(input string tag, input int cycles);
        int d;
        d = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (done) d++;
        end
        check({tag, "_no_done"}, d, 0);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        clear_coefs();
        step();
        step();
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sample", int'(sample_out), 0);

        clear_coefs();
        run_op("zero", 0, 20, 99, 0, 1'b0);
        expect_idle("zero");

        clear_coefs(); coef[0] = 19'sd100;
        run_op("dc100", 35, 20, 99, 0, 1'b0);

        // Back-to-back: start in the first IDLE cycle after FINISH.
        clear_coefs(); coef[0] = 19'sd362;
        run_op("dc362_b2b", 127, 20, 99, 0, 1'b0);
        expect_idle("dc362");

        clear_coefs(); coef[0] = -19'sd400;
        run_op("dcm400", -128, 20, 99, 0, 1'b0);
        expect_idle("dcm400");

        clear_coefs(); coef[1] = 19'sd200;
        run_op("ac1", -56, 20, 99, 0, 1'b0);
        expect_idle("ac1");

        clear_coefs(); coef[3] = -19'sd50; coef[6] = 19'sd64;
        run_op("mix36", 5, 20, 99, 0, 1'b0);
        expect_idle("mix36");

        clear_coefs(); coef[0] = 19'sd100;
        run_op("spoil", 35, 20, 99, 0, 1'b1);
        expect_idle("spoil");
        count_quiet("spoil", 25);

        clear_coefs(); coef[1] = 19'sd200;
        run_op("stall", -56, 27, 5, 7, 1'b0);
        expect_idle("stall");

        // done must persist while en is low in the done cycle.
        clear_coefs(); coef[0] = -19'sd400;
        run_op("hold", -128, 20, 99, 0, 1'b0);
        en = 1'b0;
        step(); step(); step();
        check("hold_done", int'(done), 1);
        check("hold_busy", int'(busy), 1);
        check("hold_sample", int'(sample_out), -128);
        en = 1'b1;
        step();
        check("hold_release_done", int'(done), 0);
        check("hold_release_busy", int'(busy), 0);

        // Reset at bit 10 of RUN, with en low to show reset ignores it.
        clear_coefs(); coef[0] = 19'sd362;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        en  = 1'b0;
        step();
        rst = 1'b0;
        en  = 1'b1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_sample", int'(sample_out), 0);
        count_quiet("midrst", 25);

        clear_coefs(); coef[0] = 19'sd100;
        run_op("after_rst", 35, 20, 99, 0, 1'b0);
        expect_idle("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
